// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the MEM/WB stage: register-file write source/destination
// selectors and load-type codes used by the load aligner.
package writeback_stage_pkg;

   localparam int REG_W_SRC_WIDTH = 3;
   localparam int REG_W_DST_WIDTH = 2;
   localparam int LOAD_TYPE_WIDTH = 3;

   localparam logic [REG_W_SRC_WIDTH-1:0] REG_W_SRC_ALU  = 3'd0;
   localparam logic [REG_W_SRC_WIDTH-1:0] REG_W_SRC_MEM  = 3'd1;
   localparam logic [REG_W_SRC_WIDTH-1:0] REG_W_SRC_PCA8 = 3'd2;
   localparam logic [REG_W_SRC_WIDTH-1:0] REG_W_SRC_HI   = 3'd3;
   localparam logic [REG_W_SRC_WIDTH-1:0] REG_W_SRC_LO   = 3'd4;

   localparam logic [REG_W_DST_WIDTH-1:0] REG_W_DST_RD  = 2'd0;
   localparam logic [REG_W_DST_WIDTH-1:0] REG_W_DST_RT  = 2'd1;
   localparam logic [REG_W_DST_WIDTH-1:0] REG_W_DST_R31 = 2'd2;

   localparam logic [LOAD_TYPE_WIDTH-1:0] LOAD_W  = 3'd0;
   localparam logic [LOAD_TYPE_WIDTH-1:0] LOAD_H  = 3'd1;
   localparam logic [LOAD_TYPE_WIDTH-1:0] LOAD_HU = 3'd2;
   localparam logic [LOAD_TYPE_WIDTH-1:0] LOAD_B  = 3'd3;
   localparam logic [LOAD_TYPE_WIDTH-1:0] LOAD_BU = 3'd4;

   localparam int LINK_OFFSET = 8;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB bus: memory-stage results and control in, register-file write port,
// forwarding qualifier and architectural HI/LO out.
interface writeback_stage_if #(
   parameter int W          = 32,
   parameter int REG_ADDR_W = 5
);
   import writeback_stage_pkg::*;

   logic                       in_valid;
   logic                       stall;
   logic                       flush;
   logic                       in_reg_write;
   logic [W-1:0]               in_alu_result;
   logic [W-1:0]               in_mem_data;
   logic [W-1:0]               in_pc;
   logic [REG_ADDR_W-1:0]      in_rd;
   logic [REG_ADDR_W-1:0]      in_rt;
   logic [REG_W_SRC_WIDTH-1:0] in_reg_write_src;
   logic [REG_W_DST_WIDTH-1:0] in_reg_write_dst;
   logic [LOAD_TYPE_WIDTH-1:0] in_load_type;
   logic                       in_hi_write;
   logic                       in_lo_write;
   logic [W-1:0]               in_hi_data;
   logic [W-1:0]               in_lo_data;

   logic                       write_en;
   logic [REG_ADDR_W-1:0]      reg_write_addr;
   logic [W-1:0]               reg_write_data;
   logic                       fwd_valid;
   logic [W-1:0]               hi;
   logic [W-1:0]               lo;
   logic                       wb_valid;

   modport master (
      output in_valid, stall, flush, in_reg_write, in_alu_result, in_mem_data,
             in_pc, in_rd, in_rt, in_reg_write_src, in_reg_write_dst,
             in_load_type, in_hi_write, in_lo_write, in_hi_data, in_lo_data,
      input  write_en, reg_write_addr, reg_write_data, fwd_valid, hi, lo, wb_valid
   );

   modport slave (
      input  in_valid, stall, flush, in_reg_write, in_alu_result, in_mem_data,
             in_pc, in_rd, in_rt, in_reg_write_src, in_reg_write_dst,
             in_load_type, in_hi_write, in_lo_write, in_hi_data, in_lo_data,
      output write_en, reg_write_addr, reg_write_data, fwd_valid, hi, lo, wb_valid
   );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Little-endian load aligner: picks the byte/half lane addressed by the low
// address bits and sign- or zero-extends it to a full word.
module load_align
   import writeback_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]                   raw,
   input  logic [$clog2(W/8)-1:0]         offset,
   input  logic [LOAD_TYPE_WIDTH-1:0]     load_type,
   output logic [W-1:0]                   data
);

   localparam int BYTE_LANES = W / 8;
   localparam int OFF_W      = $clog2(BYTE_LANES);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Misaligned half addresses simply drop offset[0] and use that lane.
   always_comb begin
      byte_sel = '0;
      half_sel = '0;
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (OFF_W'(i) == offset) begin
            byte_sel = raw[i*8 +: 8];
         end
      end
      for (int i = 0; i < BYTE_LANES/2; i++) begin
         if (OFF_W'(i) == (offset >> 1)) begin
            half_sel = raw[i*16 +: 16];
         end
      end
   end

   always_comb begin
      data = raw;
      case (load_type)
         LOAD_W:  data = raw;
         LOAD_H:  data = {{(W-16){half_sel[15]}}, half_sel};
         LOAD_HU: data = {{(W-16){1'b0}}, half_sel};
         LOAD_B:  data = {{(W-8){byte_sel[7]}}, byte_sel};
         LOAD_BU: data = {{(W-8){1'b0}}, byte_sel};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback muxing for the MIPS32 core; also
// owns the HI/LO pair, which reads old values and updates at the end of WB.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int W          = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   writeback_stage_if.slave   bus
);

   localparam int OFF_W = $clog2(W/8);

   logic                       wb_valid_q;
   logic                       reg_write_q;
   logic [W-1:0]               alu_result_q;
   logic [W-1:0]               mem_data_q;
   logic [W-1:0]               pc_q;
   logic [REG_ADDR_W-1:0]      rd_q;
   logic [REG_ADDR_W-1:0]      rt_q;
   logic [REG_W_SRC_WIDTH-1:0] src_q;
   logic [REG_W_DST_WIDTH-1:0] dst_q;
   logic [LOAD_TYPE_WIDTH-1:0] load_type_q;
   logic                       hi_write_q;
   logic                       lo_write_q;
   logic [W-1:0]               hi_data_q;
   logic [W-1:0]               lo_data_q;
   logic [W-1:0]               hi_q;
   logic [W-1:0]               lo_q;

   logic [W-1:0]               load_data;
   logic [REG_ADDR_W-1:0]      dst_addr;
   logic [W-1:0]               wr_data;
   logic                       wr_en;

   // Stall outranks flush so a stalled instruction is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         alu_result_q <= '0;
         mem_data_q   <= '0;
         pc_q         <= '0;
         rd_q         <= '0;
         rt_q         <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         load_type_q  <= '0;
         hi_write_q   <= 1'b0;
         lo_write_q   <= 1'b0;
         hi_data_q    <= '0;
         lo_data_q    <= '0;
      end else if (!bus.stall) begin
         if (bus.flush) begin
            wb_valid_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            pc_q         <= '0;
            rd_q         <= '0;
            rt_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            load_type_q  <= '0;
            hi_write_q   <= 1'b0;
            lo_write_q   <= 1'b0;
            hi_data_q    <= '0;
            lo_data_q    <= '0;
         end else begin
            wb_valid_q   <= bus.in_valid;
            reg_write_q  <= bus.in_reg_write;
            alu_result_q <= bus.in_alu_result;
            mem_data_q   <= bus.in_mem_data;
            pc_q         <= bus.in_pc;
            rd_q         <= bus.in_rd;
            rt_q         <= bus.in_rt;
            src_q        <= bus.in_reg_write_src;
            dst_q        <= bus.in_reg_write_dst;
            load_type_q  <= bus.in_load_type;
            hi_write_q   <= bus.in_hi_write;
            lo_write_q   <= bus.in_lo_write;
            hi_data_q    <= bus.in_hi_data;
            lo_data_q    <= bus.in_lo_data;
         end
      end
   end

   // HI/LO commit at the edge that ends the WB cycle, so MFHI/MFLO in the
   // next slot observes the freshly written value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wb_valid_q && hi_write_q && !bus.stall) begin
            hi_q <= hi_data_q;
         end
         if (wb_valid_q && lo_write_q && !bus.stall) begin
            lo_q <= lo_data_q;
         end
      end
   end

   load_align #(
      .W(W)
   ) u_load_align (
      .raw       (mem_data_q),
      .offset    (alu_result_q[OFF_W-1:0]),
      .load_type (load_type_q),
      .data      (load_data)
   );

   // Unknown destination codes map to $0, which suppresses the write.
   always_comb begin
      dst_addr = '0;
      case (dst_q)
         REG_W_DST_RD:  dst_addr = rd_q;
         REG_W_DST_RT:  dst_addr = rt_q;
         REG_W_DST_R31: dst_addr = REG_ADDR_W'(31);
         default:       dst_addr = '0;
      endcase
   end

   always_comb begin
      wr_data = '0;
      case (src_q)
         REG_W_SRC_ALU:  wr_data = alu_result_q;
         REG_W_SRC_MEM:  wr_data = load_data;
         REG_W_SRC_PCA8: wr_data = pc_q + W'(LINK_OFFSET);
         REG_W_SRC_HI:   wr_data = hi_q;
         REG_W_SRC_LO:   wr_data = lo_q;
         default:        wr_data = '0;
      endcase
   end

   assign wr_en = wb_valid_q & reg_write_q & (dst_addr != '0);

   assign bus.write_en       = wr_en;
   assign bus.fwd_valid      = wr_en;
   assign bus.reg_write_addr = dst_addr;
   assign bus.reg_write_data = wr_data;
   assign bus.hi             = hi_q;
   assign bus.lo             = lo_q;
   assign bus.wb_valid       = wb_valid_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a queue of expected write-port
// values is filled as instructions are driven and drained after each capture.
module tb_writeback_stage;
   import writeback_stage_pkg::*;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];

   writeback_stage_if #(.W(32), .REG_ADDR_W(5)) bus ();

   writeback_stage #(.W(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus();
      bus.in_valid         = 1'b0;
      bus.stall            = 1'b0;
      bus.flush            = 1'b0;
      bus.in_reg_write     = 1'b0;
      bus.in_alu_result    = '0;
      bus.in_mem_data      = '0;
      bus.in_pc            = '0;
      bus.in_rd            = '0;
      bus.in_rt            = '0;
      bus.in_reg_write_src = REG_W_SRC_ALU;
      bus.in_reg_write_dst = REG_W_DST_RD;
      bus.in_load_type     = LOAD_W;
      bus.in_hi_write      = 1'b0;
      bus.in_lo_write      = 1'b0;
      bus.in_hi_data       = '0;
      bus.in_lo_data       = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.write_en !== 1'b0 || bus.wb_valid !== 1'b0 || bus.hi !== 32'h0 ||
          bus.lo !== 32'h0 || bus.reg_write_addr !== 5'd0 || bus.reg_write_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset: we=%b valid=%b hi=%h lo=%h addr=%0d data=%h, expected all zero",
                  bus.write_en, bus.wb_valid, bus.hi, bus.lo, bus.reg_write_addr, bus.reg_write_data);
      end
   endtask

   task automatic test_load();
      logic [2:0]  lt  [8] = '{LOAD_B, LOAD_BU, LOAD_H, LOAD_HU, LOAD_B, LOAD_BU, LOAD_H, LOAD_W};
      logic [31:0] adr [8] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1001, 32'h1000, 32'h1000};
      logic [31:0] res [8] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8812, 32'h0000_8812,
                               32'hFFFF_FFF0, 32'h0000_0034, 32'h0000_34F0, 32'h8812_34F0};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         bus.in_valid         = 1'b1;
         bus.in_reg_write     = 1'b1;
         bus.in_mem_data      = 32'h8812_34F0;
         bus.in_alu_result    = adr[i];
         bus.in_load_type     = lt[i];
         bus.in_reg_write_src = REG_W_SRC_MEM;
         bus.in_rd            = 5'd7;
         sb.push_back('{we: 1'b1, addr: 5'd7, data: res[i]});
         step();
         e = sb.pop_front();
         checks++;
         if (bus.write_en !== e.we || bus.reg_write_addr !== e.addr || bus.reg_write_data !== e.data) begin
            errors++;
            $display("[TB] FAIL load%0d: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                     i, bus.write_en, bus.reg_write_addr, bus.reg_write_data, e.we, e.addr, e.data);
         end
      end
   endtask

   task automatic test_link();
      logic [31:0] pcs [2] = '{32'h0040_0010, 32'hFFFF_FFFC};
      logic [31:0] res [2] = '{32'h0040_0018, 32'h0000_0004};
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         bus.in_valid         = 1'b1;
         bus.in_reg_write     = 1'b1;
         bus.in_pc            = pcs[i];
         bus.in_rd            = 5'd3;
         bus.in_reg_write_src = REG_W_SRC_PCA8;
         bus.in_reg_write_dst = REG_W_DST_R31;
         sb.push_back('{we: 1'b1, addr: 5'd31, data: res[i]});
         step();
         e = sb.pop_front();
         checks++;
         if (bus.write_en !== e.we || bus.reg_write_addr !== e.addr || bus.reg_write_data !== e.data) begin
            errors++;
            $display("[TB] FAIL link%0d: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                     i, bus.write_en, bus.reg_write_addr, bus.reg_write_data, e.we, e.addr, e.data);
         end
      end
   endtask

   task automatic test_zero_dest();
      exp_t e;
      applyStimulus();
      bus.in_valid         = 1'b1;
      bus.in_reg_write     = 1'b1;
      bus.in_alu_result    = 32'hDEAD_BEEF;
      bus.in_rd            = 5'd9;
      bus.in_rt            = 5'd0;
      bus.in_reg_write_dst = REG_W_DST_RT;
      sb.push_back('{we: 1'b0, addr: 5'd0, data: 32'hDEAD_BEEF});
      step();
      e = sb.pop_front();
      checks++;
      if (bus.write_en !== e.we || bus.fwd_valid !== e.we || bus.reg_write_addr !== e.addr ||
          bus.reg_write_data !== e.data) begin
         errors++;
         $display("[TB] FAIL zero_dest: we=%b fwd=%b addr=%0d data=%h, expected we=0 fwd=0 addr=%0d data=%h",
                  bus.write_en, bus.fwd_valid, bus.reg_write_addr, bus.reg_write_data, e.addr, e.data);
      end
   endtask

   task automatic test_stall_flush();
      exp_t e;
      applyStimulus();
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_alu_result = 32'hCAFE_F00D;
      bus.in_rd         = 5'd9;
      sb.push_back('{we: 1'b1, addr: 5'd9, data: 32'hCAFE_F00D});
      step();
      // Stall with different inputs presented; held contents must not move.
      for (int i = 0; i < 4; i++) begin
         bus.stall         = 1'b1;
         bus.flush         = (i == 3);
         bus.in_alu_result = 32'h1111_0000 + 32'(i);
         bus.in_rd         = 5'd12;
         step();
         e = sb[0];
         checks++;
         if (bus.write_en !== e.we || bus.reg_write_addr !== e.addr ||
             bus.reg_write_data !== e.data || bus.wb_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall%0d: we=%b valid=%b addr=%0d data=%h, expected we=1 valid=1 addr=%0d data=%h",
                     i, bus.write_en, bus.wb_valid, bus.reg_write_addr, bus.reg_write_data, e.addr, e.data);
         end
      end
      void'(sb.pop_front());
      bus.stall = 1'b0;
      bus.flush = 1'b1;
      step();
      checks++;
      if (bus.wb_valid !== 1'b0 || bus.write_en !== 1'b0 || bus.reg_write_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL flush: valid=%b we=%b data=%h, expected valid=0 we=0 data=00000000",
                  bus.wb_valid, bus.write_en, bus.reg_write_data);
      end
      applyStimulus();
   endtask

   task automatic test_hilo();
      exp_t e;
      applyStimulus();
      bus.in_valid    = 1'b1;
      bus.in_hi_write = 1'b1;
      bus.in_hi_data  = 32'h1234_5678;
      step();
      applyStimulus();
      bus.in_valid         = 1'b1;
      bus.in_reg_write     = 1'b1;
      bus.in_rd            = 5'd2;
      bus.in_reg_write_src = REG_W_SRC_HI;
      sb.push_back('{we: 1'b1, addr: 5'd2, data: 32'h1234_5678});
      step();
      e = sb.pop_front();
      checks++;
      if (bus.write_en !== e.we || bus.reg_write_addr !== e.addr || bus.reg_write_data !== e.data) begin
         errors++;
         $display("[TB] FAIL mfhi: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  bus.write_en, bus.reg_write_addr, bus.reg_write_data, e.we, e.addr, e.data);
      end
      // MTLO that sits stalled in WB must not commit until the stall drops.
      applyStimulus();
      bus.in_valid    = 1'b1;
      bus.in_lo_write = 1'b1;
      bus.in_lo_data  = 32'hA5A5_A5A5;
      step();
      applyStimulus();
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus.lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mtlo_stall%0d: lo=%h, expected 00000000", i, bus.lo);
         end
      end
      bus.stall = 1'b0;
      step();
      checks++;
      if (bus.lo !== 32'hA5A5_A5A5 || bus.hi !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL mtlo_release: lo=%h hi=%h, expected lo=a5a5a5a5 hi=12345678", bus.lo, bus.hi);
      end
   endtask

   task automatic test_reset_midrun();
      applyStimulus();
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_alu_result = 32'h0000_0055;
      bus.in_rd         = 5'd5;
      step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.reg_write_addr !== 5'd5 || bus.reg_write_data !== 32'h55) begin
         errors++;
         $display("[TB] FAIL pre_reset: we=%b addr=%0d data=%h, expected we=1 addr=5 data=00000055",
                  bus.write_en, bus.reg_write_addr, bus.reg_write_data);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.write_en !== 1'b0 || bus.wb_valid !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: we=%b valid=%b hi=%h lo=%h, expected all zero",
                  bus.write_en, bus.wb_valid, bus.hi, bus.lo);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst    = 1'b0;
      applyStimulus();
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_load();
      test_link();
      test_zero_dest();
      test_stall_flush();
      test_hilo();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MEM/WB pipeline stage plus writeback logic for the MIPS32 core.
- Captures memory-stage results under stall/flush control and aligns and sign/zero-extends load data.
- Selects the register-file write source and destination, and owns the HI/LO register pair.
- Drives the register-file write port and a forwarding bus back to execute.

Parameters:
W, 32, data word width (bits)
REG_ADDR_W, 5, register-file address width
BYTE_LANES, W/8, number of byte lanes in a word; used by the load aligner

Ports:
clk  in  1  clock; every register updates on the rising edge
rst  in  1  asynchronous active-low reset; 0 clears all state immediately
in_valid  in  1  memory stage presents a valid instruction
stall  in  1  hold the WB register contents; inputs ignored
flush  in  1  squash the incoming instruction
in_reg_write  in  1  instruction writes the GPR file
in_alu_result  in  W  ALU result; low bits double as the load byte offset
in_mem_data  in  W  raw word read from data memory
in_pc  in  W  PC of the instruction
in_rd, in_rt  in  REG_ADDR_W  candidate destination registers
in_reg_write_src  in  `REG_W_SRC_WIDTH  ALU / MEM / PCA8 / HI / LO
in_reg_write_dst  in  `REG_W_DST_WIDTH  RD / RT / R31
in_load_type  in  3  LW / LH / LHU / LB / LBU
in_hi_write, in_lo_write  in  1  instruction writes HI / LO
in_hi_data, in_lo_data  in  W  new HI / LO values
write_en  out  1  GPR write strobe
reg_write_addr  out  REG_ADDR_W  GPR write address
reg_write_data  out  W  GPR write data
fwd_valid  out  1  equals write_en; forwarding qualifier
hi, lo  out  W  architectural HI and LO registers
wb_valid  out  1  WB register currently holds a valid instruction

Behaviour:
- Reset (rst=0, asynchronous): all registered fields, hi and lo go to 0; wb_valid=0; write_en=0; reg_write_addr=0; reg_write_data=0. Nothing is written until the first capture after rst returns to 1.
- Capture at rising edge, in priority order:
  - stall=1: hold all registered fields, including wb_valid. A held valid instruction keeps asserting write_en; the register-file write is idempotent.
  - else flush=1: wb_valid<=0 and all other fields <=0.
  - else: every in_* field is registered and wb_valid<=in_valid.
- stall and flush both high: stall wins.
- Latency: an instruction presented at edge N drives write_en/addr/data combinationally from the WB register during cycle N+1.
- write_en = wb_valid & reg_write & (reg_write_addr != 0). Writes to $0 are suppressed.
- Destination select:
  - RD -> rd; RT -> rt; R31 -> 31.
  - Unknown code -> address 0, which suppresses the write.
- Source select:
  - ALU -> alu_result.
  - MEM -> aligned load data.
  - PCA8 -> pc+8 (MIPS delay-slot link); wraps modulo 2^W.
  - HI -> current hi; LO -> current lo. These read the architectural registers before any same-cycle update.
  - Unknown code -> 0.
- Load alignment, little-endian; offset = alu_result[1:0]:
  - LW: whole word.
  - LH/LHU: half selected by offset[1]; sign- or zero-extended to W.
  - LB/LBU: byte selected by offset; sign- or zero-extended to W.
  - Misaligned LH/LW addresses are not checked here; exceptions belong to MEM. Data uses the truncated lane.
- HI/LO update, at the rising edge ending cycle N+1:
  - hi <= hi_data when wb_valid & hi_write & !stall.
  - lo <= lo_data when wb_valid & lo_write & !stall.
  - An MFHI following an MTHI in the next slot sees the new value.
- Outputs with wb_valid=0: write_en=0. reg_write_addr and reg_write_data still reflect the mux output, so they carry no X after reset.

Decomposition:
- defines.v gains:
  - `LOAD_W/`LOAD_H/`LOAD_HU/`LOAD_B/`LOAD_BU (3-bit codes).
  - `REG_W_SRC_PCA8, `REG_W_SRC_HI, `REG_W_SRC_LO.
  - Widened `REG_W_SRC_WIDTH (3).
  - Reuses `ZERO_WORD and `REG_ADDR_W.
- One combinational sub-module, load_align (parameter W): inputs raw word, offset, load_type; output extended word.

Test Plan:
- Reset mid-run: after capturing a valid ALU write to r5, drop rst asynchronously between edges -> write_en, wb_valid, hi and lo read 0 immediately with no clock edge.
- LB sign extension: mem_data=0x8812_34F0, alu_result=0x...03, LB -> data 0xFFFF_FF88. The same stimulus with LBU -> 0x0000_0088. LH with offset 2 -> 0xFFFF_8812.
- JAL link: pc=0x0040_0010, src=PCA8, dst=R31 -> addr 31, data 0x0040_0018, write_en=1. pc=0xFFFF_FFFC -> data 0x0000_0004.
- $0 suppression: dst=RT, rt=0, ALU result 0xDEAD_BEEF -> write_en=0, fwd_valid=0.
- Stall/flush: capture an instruction, then stall=1 for 3 cycles -> outputs constant. Assert stall=1 with flush=1 -> contents held. Assert flush=1 alone -> wb_valid=0 next cycle.
- HI/LO: MTHI 0x1234_5678 followed next cycle by an MFHI to r2 -> r2 data 0x1234_5678. A stalled MTLO -> lo unchanged until stall drops.
